// File: rtl/if_fetch_responder_if.sv
// Instruction fetch bus bundle between the core, this responder and the instruction memory.
// The slave modport is the responder's view; the master modport is the core plus memory side.
interface if_fetch_responder_if #(
  parameter int XLEN        = 32,
  parameter int PARCEL_SIZE = 32
);
  logic [XLEN-1:0]            if_nxt_pc;
  logic                       if_stall_nxt_pc;
  logic                       if_stall;
  logic                       if_flush;
  logic [PARCEL_SIZE-1:0]     if_parcel;
  logic [XLEN-1:0]            if_parcel_pc;
  logic [PARCEL_SIZE/16-1:0]  if_parcel_valid;
  logic                       if_parcel_misaligned;
  logic                       if_parcel_page_fault;
  logic                       mem_req;
  logic [XLEN-1:0]            mem_adr;
  logic                       mem_ack;
  logic [31:0]                mem_q;
  logic                       mem_err;

  modport slave (
    input  if_nxt_pc, if_stall, if_flush, mem_ack, mem_q, mem_err,
    output if_stall_nxt_pc, if_parcel, if_parcel_pc, if_parcel_valid,
           if_parcel_misaligned, if_parcel_page_fault, mem_req, mem_adr
  );

  modport master (
    output if_nxt_pc, if_stall, if_flush, mem_ack, mem_q, mem_err,
    input  if_stall_nxt_pc, if_parcel, if_parcel_pc, if_parcel_valid,
           if_parcel_misaligned, if_parcel_page_fault, mem_req, mem_adr
  );
endinterface

// File: rtl/if_fetch_responder.sv
// Memory-side fetch responder: issues word reads for accepted PCs and returns parcels in order,
// tagged with PC, misaligned and fault flags; acks for flushed requests are counted and dropped.
module if_fetch_responder #(
  parameter int XLEN        = 32,
  parameter int PARCEL_SIZE = 32,
  parameter int DEPTH       = 4
) (
  input logic                  clk,
  input logic                  rst,
  if_fetch_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [PARCEL_SIZE-1:0] data;
    logic                   done;
    logic                   misaligned;
    logic                   fault;
  } entry_t;

  entry_t          fifo [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   occ;       // entries held (issued, buffered or misaligned)
  logic [CW-1:0]   pend_cnt;  // entries still waiting for their mem_ack
  logic [CW-1:0]   drop_cnt;  // acks still owed to flushed requests

  logic            req_mis;
  logic [CW:0]     budget;
  logic            stall_nxt;
  logic            push, push_aligned, pop;
  logic            head_valid;
  logic            ack_drop, ack_fill;
  logic [AW-1:0]   ack_idx;

  // Not-done entries always form the newest pend_cnt slots: misaligned entries only enter an
  // empty FIFO and acks complete in order, so the oldest pending slot is wr_ptr - pend_cnt.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    req_mis      = |bus.if_nxt_pc[1:0];
    budget       = {1'b0, occ} + {1'b0, drop_cnt};
    stall_nxt    = rst | bus.if_flush | (budget == (CW+1)'(DEPTH)) | (req_mis & (occ != '0));
    push         = ~stall_nxt;
    push_aligned = push & ~req_mis;
    head_valid   = ~rst & (occ != '0) & fifo[rd_ptr].done;
    pop          = head_valid & ~bus.if_stall;
    ack_drop     = bus.mem_ack & (drop_cnt != '0);
    ack_fill     = bus.mem_ack & (drop_cnt == '0) & (pend_cnt != '0);
    ack_idx      = wr_ptr - pend_cnt[AW-1:0];
  end

  always_comb begin
    bus.if_stall_nxt_pc      = stall_nxt;
    bus.mem_req              = push_aligned;
    bus.mem_adr              = '0;
    bus.if_parcel            = '0;
    bus.if_parcel_pc         = '0;
    bus.if_parcel_valid      = '0;
    bus.if_parcel_misaligned = 1'b0;
    bus.if_parcel_page_fault = 1'b0;
    if (push_aligned) begin
      bus.mem_adr = {bus.if_nxt_pc[XLEN-1:2], 2'b00};
    end
    if (head_valid) begin
      bus.if_parcel            = fifo[rd_ptr].data;
      bus.if_parcel_pc         = fifo[rd_ptr].pc;
      bus.if_parcel_valid      = '1;
      bus.if_parcel_misaligned = fifo[rd_ptr].misaligned;
      bus.if_parcel_page_fault = fifo[rd_ptr].fault;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      pend_cnt <= '0;
      drop_cnt <= '0;
    end else if (bus.if_flush) begin
      // An ack in the flush cycle settles against the pre-flush counts, so it is not re-owed.
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      pend_cnt <= '0;
      drop_cnt <= drop_cnt + pend_cnt - CW'(ack_drop | ack_fill);
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ      <= occ + CW'(push) - CW'(pop);
      pend_cnt <= pend_cnt + CW'(push_aligned) - CW'(ack_fill);
      if (ack_drop) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  // NOTE: the entry storage has no reset; occ gates every read, so stale slot contents are never seen.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= '{pc: bus.if_nxt_pc, data: '0, done: req_mis, misaligned: req_mis, fault: 1'b0};
    end
    if (ack_fill && !rst && !bus.if_flush) begin
      fifo[ack_idx].data  <= bus.mem_err ? '0 : PARCEL_SIZE'(bus.mem_q);
      fifo[ack_idx].fault <= bus.mem_err;
      fifo[ack_idx].done  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch_responder.sv
// Randomized scoreboard bench for if_fetch_responder: a queue-level model predicts backpressure,
// memory requests and the exact cycle each parcel becomes visible; a monitor checks the parcels.
module tb_if_fetch_responder;
  localparam int XLEN  = 32;
  localparam int PS    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_fetch_responder_if #(.XLEN(XLEN), .PARCEL_SIZE(PS)) bus ();

  if_fetch_responder #(.XLEN(XLEN), .PARCEL_SIZE(PS), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Expected parcels in accept order; ready means the parcel is visible from the next cycle.
  typedef struct {
    int unsigned id;
    logic [31:0] pc;
    logic [31:0] data;
    logic        mis;
    logic        fault;
    logic        ready;
  } exp_t;

  // Outstanding memory reads; stale marks a read whose fetch was flushed.
  typedef struct {
    int unsigned id;
    logic        stale;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } mem_t;

  exp_t expq[$];
  mem_t memq[$];

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  bit model_on    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic int count_stale();
    int n = 0;
    foreach (memq[i]) if (memq[i].stale) n++;
    return n;
  endfunction

  // Monitor: compares whatever the DUT presents against the head of the expected queue.
  initial begin
    forever begin
      bit want;
      @(negedge clk);
      if (model_on) begin
        want = (expq.size() != 0) && expq[0].ready;
        check("parcel_valid", 64'(bus.if_parcel_valid), want ? 64'h3 : 64'h0);
        if (want) begin
          check("parcel_pc",    64'(bus.if_parcel_pc),         64'(expq[0].pc));
          check("parcel_data",  64'(bus.if_parcel),            64'(expq[0].data));
          check("misaligned",   64'(bus.if_parcel_misaligned), 64'(expq[0].mis));
          check("page_fault",   64'(bus.if_parcel_page_fault), 64'(expq[0].fault));
          if (!bus.if_stall) void'(expq.pop_front());
        end
      end
    end
  end

  // Stimulus: core and memory behaviour plus model updates.
  initial begin
    logic [31:0] pc;
    bit          pred_stall;
    bit          acking;
    bit          acc_aligned;
    int          ack_pct, stall_pct, flush_pct, mis_pct, r;
    int unsigned next_id;
    mem_t        m;
    exp_t        e;

    next_id = 0;
    rst = 1'b1;
    bus.if_nxt_pc = 32'h200;
    bus.if_stall  = 1'b0;
    bus.if_flush  = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_q     = '0;
    bus.mem_err   = 1'b0;

    @(posedge clk); #1;
    check("rst_stall_nxt_pc", 64'(bus.if_stall_nxt_pc), 64'h1);
    check("rst_mem_req",      64'(bus.mem_req),         64'h0);
    check("rst_valid",        64'(bus.if_parcel_valid), 64'h0);
    check("rst_parcel",       64'(bus.if_parcel),       64'h0);
    check("rst_parcel_pc",    64'(bus.if_parcel_pc),    64'h0);
    check("rst_misaligned",   64'(bus.if_parcel_misaligned), 64'h0);
    check("rst_page_fault",   64'(bus.if_parcel_page_fault), 64'h0);

    @(posedge clk); #1;
    rst      = 1'b0;
    model_on = 1'b1;
    pc       = 32'h200;

    for (int c = 0; c < 2500; c++) begin
      cycle = c;
      case (c / 500)
        0:       begin ack_pct = 70;  stall_pct = 20; flush_pct = 3;  mis_pct = 8;  end
        1:       begin ack_pct = 5;   stall_pct = 10; flush_pct = 2;  mis_pct = 5;  end
        2:       begin ack_pct = 90;  stall_pct = 60; flush_pct = 3;  mis_pct = 8;  end
        3:       begin ack_pct = 100; stall_pct = 0;  flush_pct = 0;  mis_pct = 0;  end
        default: begin ack_pct = 40;  stall_pct = 30; flush_pct = 10; mis_pct = 15; end
      endcase

      // Memory acks in order, never in the cycle of the request itself.
      acking = (memq.size() != 0) && (memq[0].cyc < c) && ($urandom_range(99) < ack_pct);
      bus.mem_ack   = acking;
      bus.mem_q     = acking ? memq[0].data : $urandom;
      bus.mem_err   = acking ? memq[0].err : 1'b0;
      bus.if_stall  = ($urandom_range(99) < stall_pct);
      bus.if_flush  = ($urandom_range(99) < flush_pct);
      bus.if_nxt_pc = pc;
      #1;

      pred_stall  = bus.if_flush || ((expq.size() + count_stale()) == DEPTH) ||
                    ((pc[1:0] != 2'b00) && (expq.size() != 0));
      acc_aligned = !pred_stall && (pc[1:0] == 2'b00);
      check("stall_nxt_pc", 64'(bus.if_stall_nxt_pc), 64'(pred_stall));
      check("mem_req",      64'(bus.mem_req),         64'(acc_aligned));
      if (acc_aligned) check("mem_adr", 64'(bus.mem_adr), 64'(pc & ~32'h3));

      @(negedge clk); #1;

      if (acking) begin
        m = memq.pop_front();
        if (!m.stale) begin
          foreach (expq[i]) if (expq[i].id == m.id) expq[i].ready = 1'b1;
        end
      end

      if (!pred_stall) begin
        e.id    = next_id;
        e.pc    = pc;
        e.mis   = (pc[1:0] != 2'b00);
        e.ready = e.mis;
        e.data  = '0;
        e.fault = 1'b0;
        if (!e.mis) begin
          m.id    = next_id;
          m.stale = 1'b0;
          m.data  = $urandom;
          m.err   = ($urandom_range(99) < 10);
          m.cyc   = c;
          memq.push_back(m);
          e.fault = m.err;
          e.data  = m.err ? 32'h0 : m.data;
        end
        expq.push_back(e);
        next_id++;
        r = $urandom_range(99);
        if (r < mis_pct)      pc = (pc & ~32'h3) + 32'h4 + 32'($urandom_range(1, 3));
        else if (r < 80)      pc = (pc & ~32'h3) + 32'h4;
        else                  pc = 32'h1000 + {22'($urandom_range(0, 1023)), 2'b00};
      end

      if (bus.if_flush) begin
        expq.delete();
        foreach (memq[i]) memq[i].stale = 1'b1;
        pc = 32'h400 + {22'($urandom_range(0, 255)), 2'b00};
      end

      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
